ctrl_pkt_gen: RTL and testbench
===============================

Name: ctrl_pkt_gen

Overview:
- Transmit-side counterpart of the control-path parser: builds Ethernet/VLAN/IPv4/UDP control packets that the parser steers onto its control branch (UDP dst port CTRL_PORT).
- Buffers a command payload of up to MAX_PAYLOAD_BEATS 512-bit beats, then emits one header beat and the buffered payload beats on a 512-bit AXI-Stream master.
- Sits between the control-plane command source and the ingress mux of the packet pipeline.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, stream data width (only 512 supported).
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- CTRL_PORT, 16'hf1f2, value of tdata[335:320] in header beat (UDP dst port slice).
- VLAN_TCI, 16'h0002, bytes 14-15.
- SRC_IP, 32'hc0a80101, IPv4 source.
- DST_IP, 32'hc0a80102, IPv4 destination.
- MAX_PAYLOAD_BEATS, 4, payload buffer depth (power of 2, 1..16).

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_tdata  in  512  payload beat (all 64 bytes valid)
- cmd_tvalid  in  1  payload beat valid
- cmd_tready  out  1  payload beat accept
- cmd_tlast  in  1  last payload beat of command
- m_axis_tdata  out  512  packet data, byte 0 at [7:0]
- m_axis_tkeep  out  64  byte enables
- m_axis_tuser  out  128  [15:0] frame length in bytes, rest 0
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat of frame
- busy  out  1  high when state != IDLE
- err_overflow  out  1  sticky: command exceeded MAX_PAYLOAD_BEATS

Behaviour:
- Reset (async, aresetn=0): state=IDLE, beat count N=0, all outputs 0 except cmd_tready=0; err_overflow cleared. Takes effect immediately mid-frame; partial frame is abandoned, m_axis_tvalid drops without tlast.
- States: IDLE -> COLLECT -> HDR -> PAYLOAD -> IDLE.
- IDLE: cmd_tready=1 from first cycle after reset release; accepted beat written to buffer[0], N=1; go to COLLECT, or straight to HDR if cmd_tlast.
- COLLECT: cmd_tready=1; each accepted beat written to buffer[N], N++. Beat with cmd_tlast -> HDR. Beats arriving after N==MAX_PAYLOAD_BEATS are accepted and dropped, err_overflow set; packet sent with N=MAX once tlast arrives.
- HDR: cmd_tready=0; m_axis_tvalid=1, tkeep=all ones, tlast=0; header beat registered, valid the cycle after cmd_tlast accepted (latency 1). Held stable until m_axis_tready.
- Header beat bytes: 0-5 ff..ff dst MAC; 6-11 SRC MAC 00 01 02 03 04 05; 12-13 81 00; 14-15 VLAN_TCI (network order); 16-17 08 00 (tdata[143:128]=16'h0008); 18 0x45; 19 0x00; 20-21 IP total len; 22-23 0; 24-25 40 00; 26 TTL 0x40; 27 0x11; 28-29 IP checksum; 30-33 SRC_IP; 34-37 DST_IP; 38-39 UDP src port = CTRL_PORT slice; 40-41 such that tdata[335:320]==CTRL_PORT; 42-43 UDP length; 44-45 UDP checksum 0; 46-63 zero.
- Lengths, 16-bit, network order: UDP len = 26 + 64*N; IP total len = UDP len + 20; tuser[15:0] = 64*(N+1), same on every beat.
- PAYLOAD: buffer[0..N-1] emitted in order, tkeep all ones, tlast on beat N-1; advance only on tvalid&tready; after last handshake -> IDLE, N=0; next command accepted the following cycle.
- AXIS: tdata/tkeep/tlast/tuser never change while tvalid=1 and tready=0.

Optional Feature:
- IP_CSUM_EN: defined -> bytes 28-29 carry the IPv4 header ones-complement checksum (header words summed with checksum field 0, end-around carry, inverted), computed on the COLLECT->HDR transition with no added latency. Undefined -> bytes 28-29 = 0.

Test Plan:
- Single 1-beat command, m_axis_tready=1 -> 2 beats: header (tdata[143:128]=16'h0008, [223:216]=8'h11, [335:320]=16'hf1f2, UDP len 90, IP len 110, tuser=128), payload beat identical to input with tlast=1.
- 3-beat command, m_axis_tready toggling 1/0 each cycle -> 4 beats, stable data under stall, UDP len 218, tuser=256.
- 6-beat command, MAX_PAYLOAD_BEATS=4 -> err_overflow=1, 5-beat frame containing beats 0-3 only.
- Back-to-back commands -> second command's cmd_tready rises the cycle after first frame's tlast handshake; no beat lost.
- aresetn pulsed low during PAYLOAD beat 2 -> all outputs 0 immediately; next 1-beat command produces correct 2-beat frame.
- IP_CSUM_EN defined, 1-beat command with defaults -> bytes 28-29 match software-computed checksum over the 20-byte IPv4 header.

Source files
------------

// File: rtl/ctrl_pkt_gen.sv
// Control packet generator: buffers a command payload, then emits an Eth/VLAN/IPv4/UDP header beat plus payload beats.
// Latency: header valid one cycle after the command's tlast beat is accepted. Output held stable under m_axis_tready=0.
// Optional IP_CSUM_EN: when defined, the IPv4 header checksum is filled in; otherwise bytes 28-29 are zero.
module ctrl_pkt_gen #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_PORT            = 16'hf1f2,
    parameter logic [15:0] VLAN_TCI             = 16'h0002,
    parameter logic [31:0] SRC_IP               = 32'hc0a80101,
    parameter logic [31:0] DST_IP               = 32'hc0a80102,
    parameter int          MAX_PAYLOAD_BEATS    = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    cmd_tdata,
    input  logic                              cmd_tvalid,
    output logic                              cmd_tready,
    input  logic                              cmd_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              err_overflow
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int AW = (MAX_PAYLOAD_BEATS > 1) ? $clog2(MAX_PAYLOAD_BEATS) : 1;
    localparam int CW = $clog2(MAX_PAYLOAD_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HDR, PAYLOAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            err_q, err_d;
    logic            live_q;
    logic [DW-1:0]   hdr_q, hdr_d;
    logic [DW-1:0]   buf_q [MAX_PAYLOAD_BEATS];

    logic            cmd_acc;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic            last_beat;
    logic            hdr_ld;
    logic [15:0]     udp_len_d, ip_len_d, csum_d, frame_len;

    function automatic logic [15:0] net16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

`ifdef IP_CSUM_EN
    function automatic logic [15:0] ip_csum(input logic [15:0] tot_len);
        logic [31:0] s;
        s = 32'h4500 + 32'(tot_len) + 32'h4000 + 32'h4011
          + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
          + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction
`endif

    assign cmd_acc   = cmd_tvalid & cmd_tready;
    assign last_beat = (CW'(rd_q) == cnt_q - CW'(1));
    assign hdr_ld    = (state_q == IDLE || state_q == COLLECT) && (state_d == HDR);

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_acc) state_d = cmd_tlast ? HDR : COLLECT;
            COLLECT: if (cmd_acc && cmd_tlast) state_d = HDR;
            HDR:     if (m_axis_tready) state_d = PAYLOAD;
            PAYLOAD: if (m_axis_tready && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat count, read pointer and buffer write control
    always_comb begin
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = '0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    wr_en = 1'b1;
                    cnt_d = CW'(1);
                end
            end
            COLLECT: begin
                if (cmd_acc) begin
                    // Beats past the buffer depth are swallowed so the command still terminates cleanly.
                    if (cnt_q < CW'(MAX_PAYLOAD_BEATS)) begin
                        wr_en  = 1'b1;
                        wr_idx = cnt_q[AW-1:0];
                        cnt_d  = cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR: rd_d = '0;
            PAYLOAD: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        rd_d  = '0;
                    end else begin
                        rd_d = rd_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign udp_len_d = 16'd26 + (16'(cnt_d) << 6);
    assign ip_len_d  = udp_len_d + 16'd20;
    assign frame_len = (16'(cnt_q) + 16'd1) << 6;

`ifdef IP_CSUM_EN
    assign csum_d = ip_csum(ip_len_d);
`else
    assign csum_d = 16'h0000;
`endif

    // Header beat, built from the final beat count and captured as the command closes
    always_comb begin
        hdr_d = '0;
        for (int k = 0; k < 6; k++) begin
            hdr_d[8*k +: 8]     = 8'hff;
            hdr_d[8*(k+6) +: 8] = 8'(k);
        end
        hdr_d[8*12 +: 16] = net16(16'h8100);
        hdr_d[8*14 +: 16] = net16(VLAN_TCI);
        hdr_d[8*16 +: 16] = net16(16'h0800);
        hdr_d[8*18 +: 16] = net16(16'h4500);
        hdr_d[8*20 +: 16] = net16(ip_len_d);
        hdr_d[8*24 +: 16] = net16(16'h4000);
        hdr_d[8*26 +: 16] = net16(16'h4011);
        hdr_d[8*28 +: 16] = net16(csum_d);
        hdr_d[8*30 +: 16] = net16(SRC_IP[31:16]);
        hdr_d[8*32 +: 16] = net16(SRC_IP[15:0]);
        hdr_d[8*34 +: 16] = net16(DST_IP[31:16]);
        hdr_d[8*36 +: 16] = net16(DST_IP[15:0]);
        // Both port fields carry CTRL_PORT as a raw slice so the parser matches tdata[335:320] directly.
        hdr_d[8*38 +: 16] = CTRL_PORT;
        hdr_d[8*40 +: 16] = CTRL_PORT;
        hdr_d[8*42 +: 16] = net16(udp_len_d);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            live_q <= 1'b0;
            hdr_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
            live_q <= 1'b1;
            if (hdr_ld) hdr_q <= hdr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_idx] <= cmd_tdata;
    end

    // Output logic
    always_comb begin
        cmd_tready    = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            IDLE, COLLECT: cmd_tready = live_q;
            HDR: begin
                m_axis_tvalid      = 1'b1;
                m_axis_tdata       = hdr_q;
                m_axis_tkeep       = '1;
                m_axis_tuser[15:0] = frame_len;
            end
            PAYLOAD: begin
                m_axis_tvalid      = 1'b1;
                m_axis_tdata       = buf_q[rd_q];
                m_axis_tkeep       = '1;
                m_axis_tuser[15:0] = frame_len;
                m_axis_tlast       = last_beat;
            end
            default: ;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign err_overflow = err_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Bench for ctrl_pkt_gen: random commands, byte-level packet model, scoreboard queue popped by an output monitor.
module tb_ctrl_pkt_gen;

    localparam int          MAXB      = 4;
    localparam logic [15:0] CTRL_PORT = 16'hf1f2;
    localparam logic [15:0] VLAN_TCI  = 16'h0002;
    localparam logic [31:0] SRC_IP    = 32'hc0a80101;
    localparam logic [31:0] DST_IP    = 32'hc0a80102;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [511:0] cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready;
    logic         cmd_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         busy;
    logic         err_overflow;

    ctrl_pkt_gen dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .cmd_tdata     (cmd_tdata),
        .cmd_tvalid    (cmd_tvalid),
        .cmd_tready    (cmd_tready),
        .cmd_tlast     (cmd_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [127:0] user;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    logic  err_exp = 1'b0;
    int    rdy_mode = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Packet header written byte by byte in wire order, then packed with byte 0 at [7:0]
    function automatic logic [511:0] model_hdr(input int n);
        logic [7:0]   b [64];
        logic [511:0] d;
        int           udp;
        int           ip;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = 8'hff;
            b[6 + i] = 8'(i);
        end
        udp = 26 + 64 * n;
        ip  = udp + 20;
        b[12] = 8'h81;              b[13] = 8'h00;
        b[14] = VLAN_TCI[15:8];     b[15] = VLAN_TCI[7:0];
        b[16] = 8'h08;              b[17] = 8'h00;
        b[18] = 8'h45;              b[19] = 8'h00;
        b[20] = 8'(ip >> 8);        b[21] = 8'(ip);
        b[24] = 8'h40;              b[25] = 8'h00;
        b[26] = 8'h40;              b[27] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            b[30 + i] = 8'(SRC_IP >> (24 - 8 * i));
            b[34 + i] = 8'(DST_IP >> (24 - 8 * i));
        end
        b[38] = CTRL_PORT[7:0];     b[39] = CTRL_PORT[15:8];
        b[40] = CTRL_PORT[7:0];     b[41] = CTRL_PORT[15:8];
        b[42] = 8'(udp >> 8);       b[43] = 8'(udp);
`ifdef IP_CSUM_EN
        begin
            int s;
            s = 0;
            for (int i = 0; i < 10; i++) s = s + (int'(b[18 + 2*i]) << 8) + int'(b[19 + 2*i]);
            while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
            s = ~s & 32'hffff;
            b[28] = 8'(s >> 8);
            b[29] = 8'(s);
        end
`endif
        for (int i = 0; i < 64; i++) d[8*i +: 8] = b[i];
        return d;
    endfunction

    // Ready pattern for the output port, updated just after each rising edge
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every handshake, checks hold-under-stall and ready recovery
    initial begin
        logic         prev_stall;
        logic         rdy_next;
        logic [511:0] p_data;
        logic [127:0] p_user;
        logic         p_last;
        beat_t        e;
        prev_stall = 1'b0;
        rdy_next   = 1'b0;
        p_data = '0; p_user = '0; p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                rdy_next   = 1'b0;
            end else begin
                if (rdy_next) chk("cmd_tready_after_tlast", 512'(cmd_tready), 512'(1));
                rdy_next = 1'b0;
                if (prev_stall) begin
                    chk("stall_tvalid", 512'(m_axis_tvalid), 512'(1));
                    chk("stall_tdata", m_axis_tdata, p_data);
                    chk("stall_tuser", 512'(m_axis_tuser), 512'(p_user));
                    chk("stall_tlast", 512'(m_axis_tlast), 512'(p_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 512'(m_axis_tvalid), 512'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_tdata", m_axis_tdata, e.data);
                        chk("beat_tlast", 512'(m_axis_tlast), 512'(e.last));
                        chk("beat_tuser", 512'(m_axis_tuser), 512'(e.user));
                        chk("beat_tkeep", 512'(m_axis_tkeep), 512'({64{1'b1}}));
                        chk("beat_busy", 512'(busy), 512'(1));
                    end
                    pops++;
                    if (m_axis_tlast) begin
                        chk("cmd_tready_during_frame", 512'(cmd_tready), 512'(0));
                        rdy_next = 1'b1;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                p_data = m_axis_tdata;
                p_user = m_axis_tuser;
                p_last = m_axis_tlast;
            end
        end
    end

    // Pushes the expected frame, then offers the beats; returns just after the last beat is accepted
    task automatic send_cmd(input int nb);
        logic [511:0] beats[$];
        beat_t        e;
        int           n;
        logic         ok;
        for (int i = 0; i < nb; i++) beats.push_back(rand512());
        n = (nb > MAXB) ? MAXB : nb;
        e.data = model_hdr(n);
        e.last = 1'b0;
        e.user = 128'(64 * (n + 1));
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.data = beats[i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        if (nb > MAXB) err_exp = 1'b1;
        for (int i = 0; i < nb; i++) begin
            cmd_tvalid = 1'b1;
            cmd_tdata  = beats[i];
            cmd_tlast  = (i == nb - 1);
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk);
                ok = cmd_tready;
                @(posedge clk);
                #1;
            end
            if (!ok) chk("cmd_accept_timeout", 512'(0), 512'(1));
        end
        cmd_tvalid = 1'b0;
        cmd_tlast  = 1'b0;
        chk("err_overflow", 512'(err_overflow), 512'(err_exp));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 512'(busy), 512'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tvalid"}, 512'(m_axis_tvalid), 512'(0));
        chk({tag, "_tlast"}, 512'(m_axis_tlast), 512'(0));
        chk({tag, "_tdata"}, m_axis_tdata, 512'(0));
        chk({tag, "_tkeep"}, 512'(m_axis_tkeep), 512'(0));
        chk({tag, "_tuser"}, 512'(m_axis_tuser), 512'(0));
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_cmd_tready"}, 512'(cmd_tready), 512'(0));
        chk({tag, "_err"}, 512'(err_overflow), 512'(0));
    endtask

    initial begin
        int base;
        int t;
        aresetn    = 1'b0;
        cmd_tvalid = 1'b0;
        cmd_tlast  = 1'b0;
        cmd_tdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 512'(cmd_tready), 512'(1));

        rdy_mode = 0;
        send_cmd(1);
        drain();

        rdy_mode = 1;
        send_cmd(3);
        drain();

        for (int k = 0; k < 12; k++) begin
            rdy_mode = $urandom_range(0, 2);
            send_cmd($urandom_range(1, MAXB));
            drain();
        end

        rdy_mode = 0;
        send_cmd(6);
        drain();

        rdy_mode = 2;
        send_cmd($urandom_range(1, 6));
        send_cmd($urandom_range(1, 6));
        send_cmd($urandom_range(1, 6));
        drain();

        // Abort a frame while its third beat is on the bus
        rdy_mode = 0;
        base = pops;
        send_cmd(3);
        t = 0;
        while (pops < base + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (pops < base + 2) chk("abort_wait_timeout", 512'(pops - base), 512'(2));
        @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        err_exp = 1'b0;
        check_zero_outputs("midframe_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midframe_reset", 512'(cmd_tready), 512'(1));
        send_cmd(1);
        drain();

        chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
